// File: rtl/peripheral_axi4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_axi4_pkg
// Description : Shared AXI4 read-master types, response codes and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package peripheral_axi4_pkg;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_exokay = 2'b01;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    localparam logic [2:0] c_size_4b = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } rsp_t;

    localparam int c_rsp_w = $bits(rsp_t);

endpackage
`default_nettype wire

// File: rtl/peripheral_axi4_fifo.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_axi4_fifo
// Description : Synchronous FIFO with combinational head and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_axi4_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_full_count = (c_addr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                w_push;
    logic                w_pop;

    assign o_full    = (r_count == c_full_count);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_push = i_wr_en && !o_full;
    assign w_pop  = i_rd_en && !o_empty;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/peripheral_axi4_read_master.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_axi4_read_master
// Description : Single-outstanding AXI4 read master with per-beat response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_axi4_read_master
    import peripheral_axi4_pkg::*;
#(
    parameter logic [3:0] ID         = 4'h0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_len,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic        proto_err
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [31:0]  r_araddr;
    logic [3:0]   r_arlen;
    logic         r_arvalid;
    logic [3:0]   r_cnt;
    logic         r_proto_err;

    logic         w_req_fire;
    logic         w_ar_fire;
    logic         w_r_fire;
    logic         w_beat_err;
    logic         w_proto_err;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic         w_unused_count;
    rsp_t         w_push_rsp;
    rsp_t         w_head_rsp;

    assign arid    = ID;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = c_size_4b;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign arvalid = r_arvalid;

    assign req_ready = (r_state == IDLE);
    assign rready    = (r_state == DATA) && !w_fifo_full;
    assign proto_err = r_proto_err;

    assign w_req_fire = req_valid && req_ready;
    assign w_ar_fire  = r_arvalid && arready;
    assign w_r_fire   = rvalid && rready;
    assign w_beat_err = (rresp != c_resp_okay) || (rid != ID);

    // Flags both an early rlast and a burst that runs past arlen without rlast.
    assign w_proto_err = w_r_fire && (rlast ? (r_cnt != r_arlen) : (r_cnt == r_arlen));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (req_valid) w_state_nxt = ADDR;
            ADDR: if (w_ar_fire) w_state_nxt = DATA;
            DATA: if (w_r_fire && rlast) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_arvalid   <= 1'b0;
            r_cnt       <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= w_proto_err;
            if (w_req_fire) begin
                r_araddr  <= req_addr;
                r_arlen   <= req_len;
                r_arvalid <= 1'b1;
            end else if (w_ar_fire) begin
                r_arvalid <= 1'b0;
            end
            if (w_ar_fire) begin
                r_cnt <= '0;
            end else if (w_r_fire && (r_cnt != 4'hf)) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign w_push_rsp = '{data: rdata, last: rlast, err: w_beat_err};

    peripheral_axi4_fifo #(
        .WIDTH (c_rsp_w),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .i_wr_en   (w_r_fire),
        .i_wr_data (w_push_rsp),
        .i_rd_en   (rsp_ready),
        .o_rd_data (w_head_rsp),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign w_unused_count = ^w_fifo_count;

    assign rsp_valid = !w_fifo_empty;
    assign rsp_data  = w_head_rsp.data;
    assign rsp_last  = w_head_rsp.last;
    assign rsp_err   = w_head_rsp.err;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_axi4_read_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_axi4_read_master
// Description : Directed and randomized bench with a queue-based response model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_axi4_read_master;

    localparam logic [3:0] c_tb_id    = 4'h0;
    localparam int         c_depth    = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last, rsp_err, proto_err;

    peripheral_axi4_read_master #(.ID(c_tb_id), .FIFO_DEPTH(c_depth)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_err(rsp_err), .proto_err(proto_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cur_len;
    int   beat_idx;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, expv);
            $error("%s observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic issue_cmd(input logic [31:0] addr, input logic [3:0] len);
        int waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk("req_ready_before_cmd", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom();
        req_len   = 4'($urandom());
        cur_len   = int'(len);
        beat_idx  = 0;
        chk("arvalid_after_cmd", arvalid, 1);
        chk("araddr", araddr, addr);
        chk("arlen", arlen, len);
        chk("req_ready_busy", req_ready, 0);
    endtask

    task automatic ar_phase(input int delay, input logic [31:0] addr);
        arready = 1'b0;
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("arvalid_held", arvalid, 1);
            chk("araddr_stable", araddr, addr);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("arvalid_dropped", arvalid, 0);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [1:0] resp,
                             input logic [3:0] id, input logic last);
        int   waited = 0;
        logic exp_p;
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rid    = id;
        rlast  = last;
        while (rready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited == 20) begin
            chk("rready_wait", rready, 1);
            rvalid = 1'b0;
            return;
        end
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        exp_p  = last ? (beat_idx != cur_len) : (beat_idx == cur_len);
        exp_q.push_back('{d, last, (resp != 2'b00) || (id != c_tb_id)});
        if (beat_idx < 15) beat_idx++;
        chk("proto_err", proto_err, exp_p);
        chk("rsp_valid_after_beat", rsp_valid, 1);
    endtask

    task automatic pop_check();
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_valid_head", rsp_valid, 1);
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_last", rsp_last, e.l);
        chk("rsp_err", rsp_err, e.e);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic drain_all();
        while (exp_q.size() > 0) pop_check();
        chk("rsp_valid_drained", rsp_valid, 0);
    endtask

    initial begin
        logic [31:0] addr;
        logic [1:0]  resp;
        logic [3:0]  id;
        int          len;

        aresetn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        arready   = 1'b0;
        rid       = '0;
        rdata     = '0;
        rresp     = '0;
        rlast     = 1'b0;
        rvalid    = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rready", rready, 0);
        aresetn = 1'b1;
        tick();

        chk("arid", arid, c_tb_id);
        chk("arsize", arsize, 3'b010);
        chk("arlock_arcache_arprot", {arlock, arcache, arprot}, 0);

        // Single beat with arready already high on the first arvalid cycle.
        issue_cmd(32'h0000_1000, 4'd0);
        ar_phase(0, 32'h0000_1000);
        send_beat(32'hDEAD_BEEF, 2'b00, c_tb_id, 1'b1);
        chk("req_ready_after_rlast", req_ready, 1);
        drain_all();

        // Four beats, delayed arready, consumer stalled until the burst ends.
        issue_cmd(32'h0000_2000, 4'd3);
        ar_phase(3, 32'h0000_2000);
        for (int i = 0; i < 4; i++) send_beat(32'(i), 2'b00, c_tb_id, i == 3);
        chk("rready_after_burst", rready, 0);
        drain_all();

        // Error status from rresp and from a foreign rid.
        issue_cmd(32'h0000_3000, 4'd1);
        ar_phase(1, 32'h0000_3000);
        send_beat($urandom(), 2'b10, c_tb_id, 1'b0);
        send_beat($urandom(), 2'b00, 4'h5, 1'b1);
        drain_all();

        // Early rlast.
        issue_cmd(32'h0000_4000, 4'd3);
        ar_phase(0, 32'h0000_4000);
        send_beat($urandom(), 2'b00, c_tb_id, 1'b0);
        send_beat($urandom(), 2'b00, c_tb_id, 1'b1);
        tick();
        chk("proto_err_single_pulse", proto_err, 0);
        chk("req_ready_early_rlast", req_ready, 1);
        drain_all();

        // Missing rlast: burst overruns arlen by one beat.
        issue_cmd(32'h0000_5000, 4'd1);
        ar_phase(2, 32'h0000_5000);
        send_beat($urandom(), 2'b00, c_tb_id, 1'b0);
        send_beat($urandom(), 2'b00, c_tb_id, 1'b0);
        chk("rready_overrun", rready, 1);
        send_beat($urandom(), 2'b00, c_tb_id, 1'b1);
        chk("req_ready_after_overrun", req_ready, 1);
        drain_all();

        // Full FIFO back-pressures the R channel until one entry is popped.
        issue_cmd(32'h0000_6000, 4'd4);
        ar_phase(0, 32'h0000_6000);
        for (int i = 0; i < 4; i++) send_beat($urandom(), 2'b00, c_tb_id, 1'b0);
        rvalid = 1'b1;
        rlast  = 1'b1;
        chk("rready_full", rready, 0);
        tick();
        chk("rready_full_held", rready, 0);
        pop_check();
        chk("rready_after_pop", rready, 1);
        send_beat(32'hCAFE_0005, 2'b00, c_tb_id, 1'b1);
        drain_all();

        // Randomized bursts with random pops and error injection.
        for (int k = 0; k < 12; k++) begin
            len  = $urandom_range(0, 6);
            addr = $urandom();
            addr[1:0] = 2'b00;
            issue_cmd(addr, 4'(len));
            ar_phase($urandom_range(0, 3), addr);
            for (int i = 0; i <= len; i++) begin
                if (exp_q.size() == c_depth) pop_check();
                else if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) pop_check();
                resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                id   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : c_tb_id;
                send_beat($urandom(), resp, id, i == len);
            end
        end
        drain_all();

        // Asynchronous reset in the middle of an eight-beat burst.
        issue_cmd(32'h0000_7000, 4'd7);
        ar_phase(0, 32'h0000_7000);
        send_beat($urandom(), 2'b00, c_tb_id, 1'b0);
        send_beat($urandom(), 2'b00, c_tb_id, 1'b0);
        rvalid = 1'b1;
        rdata  = $urandom();
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rst_arvalid", arvalid, 0);
        chk("async_rst_rready", rready, 0);
        chk("async_rst_rsp_valid", rsp_valid, 0);
        chk("async_rst_req_ready", req_ready, 1);
        rvalid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        tick();
        issue_cmd(32'h0000_8000, 4'd1);
        ar_phase(1, 32'h0000_8000);
        send_beat(32'h1234_5678, 2'b00, c_tb_id, 1'b0);
        send_beat(32'h9ABC_DEF0, 2'b00, c_tb_id, 1'b1);
        chk("req_ready_post_reset", req_ready, 1);
        drain_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
